// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types for the cache fill arbiter: FSM states, fill source select and
// block geometry (16-byte blocks of eight 16-bit words).
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL
  } fill_state_e;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } fill_src_e;

  localparam int unsigned BLOCK_OFFSET_W = 4;
  localparam int unsigned WORD_IDX_W     = 3;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-controller and memory-port signal bundle for cache_fill_arbiter.
// master = arbiter side, slave = caches plus memory side.
interface cache_fill_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              icache_miss;
  logic [ADDR_W-1:0] icache_miss_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_miss_addr;
  logic              dcache_wr_req;
  logic [ADDR_W-1:0] dcache_wr_addr;
  logic [15:0]       dcache_wr_data;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;
  logic              fill_we;
  logic              fill_sel;
  logic [ADDR_W-1:0] fill_addr;
  logic [15:0]       fill_data;
  logic              fill_tag_we;
  logic              icache_fill_done;
  logic              dcache_fill_done;
  logic              busy;

  modport master (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_rdata, mem_rvalid,
    output wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel,
           fill_addr, fill_data, fill_tag_we, icache_fill_done, dcache_fill_done, busy
  );

  modport slave (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_rdata, mem_rvalid,
    input  wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel,
           fill_addr, fill_data, fill_tag_we, icache_fill_done, dcache_fill_done, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D block fills and D write-through stores onto one pipelined memory port.
// Optional macro CRITICAL_WORD_FIRST_EN: fill order starts at the missed word.
module cache_fill_arbiter
  import cache_fill_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_fill_arbiter_if.master bus
);

  localparam int unsigned       CNT_W       = WORD_IDX_W + 1;
  localparam logic [CNT_W-1:0]  BLK_WORDS   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << BLOCK_OFFSET_W) - 1);

  fill_state_e             state_q, state_d;
  fill_src_e               src_q, src_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        recv_cnt_q, recv_cnt_d;
  logic [WORD_IDX_W-1:0]   issue_idx, recv_idx;
  logic [ADDR_W-1:0]       req_addr;
  logic                    in_fill, issuing, receiving, last_word;

  // Word offset is OR-ed under a cleared block offset, so it can never carry into the tag.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [WORD_IDX_W-1:0] idx);
    return base | {{(ADDR_W - BLOCK_OFFSET_W){1'b0}}, idx, 1'b0};
  endfunction

`ifdef CRITICAL_WORD_FIRST_EN
  logic [WORD_IDX_W-1:0] start_q, start_d;

  always_comb begin
    issue_idx = start_q + issue_cnt_q[WORD_IDX_W-1:0];
    recv_idx  = start_q + recv_cnt_q[WORD_IDX_W-1:0];
  end
`else
  always_comb begin
    issue_idx = issue_cnt_q[WORD_IDX_W-1:0];
    recv_idx  = recv_cnt_q[WORD_IDX_W-1:0];
  end
`endif

  always_comb begin
    in_fill   = (state_q == FILL);
    issuing   = in_fill && (issue_cnt_q < BLK_WORDS);
    receiving = in_fill && bus.mem_rvalid;
    last_word = receiving && (recv_cnt_q == LAST_WORD);
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
`ifdef CRITICAL_WORD_FIRST_EN
    start_d     = start_q;
`endif
    req_addr    = bus.dcache_miss ? bus.dcache_miss_addr : bus.icache_miss_addr;
    case (state_q)
      IDLE: begin
        // Priority dcache_miss > dcache_wr_req > icache_miss; a store miss fills before writing.
        if (bus.dcache_miss || (bus.icache_miss && !bus.dcache_wr_req)) begin
          state_d     = FILL;
          src_d       = bus.dcache_miss ? SRC_DCACHE : SRC_ICACHE;
          base_d      = req_addr & ~OFFSET_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
`ifdef CRITICAL_WORD_FIRST_EN
          start_d     = req_addr[BLOCK_OFFSET_W-1:1];
`endif
        end else if (bus.dcache_wr_req) begin
          state_d = WRITE;
        end
      end
      WRITE: state_d = IDLE;
      FILL: begin
        if (issuing)   issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (receiving) recv_cnt_d  = recv_cnt_q + CNT_W'(1);
        if (last_word) state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_ICACHE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q     <= start_d;
`endif
    end
  end

  always_comb begin
    bus.busy             = (state_q != IDLE);
    bus.wr_ack           = (state_q == WRITE);
    bus.mem_en           = issuing || (state_q == WRITE);
    bus.mem_wr           = (state_q == WRITE);
    bus.mem_addr         = '0;
    bus.mem_wdata        = '0;
    if (state_q == WRITE) begin
      bus.mem_addr  = bus.dcache_wr_addr;
      bus.mem_wdata = bus.dcache_wr_data;
    end else if (issuing) begin
      bus.mem_addr  = word_addr(base_q, issue_idx);
    end
    // mem_rvalid outside FILL is a leftover from an abandoned fill and is dropped.
    bus.fill_we          = receiving;
    bus.fill_sel         = src_q;
    bus.fill_addr        = receiving ? word_addr(base_q, recv_idx) : '0;
    bus.fill_data        = receiving ? bus.mem_rdata : '0;
    bus.fill_tag_we      = last_word;
    bus.icache_fill_done = last_word && (src_q == SRC_ICACHE);
    bus.dcache_fill_done = last_word && (src_q == SRC_DCACHE);
  end

  // Pipelined memory: at most MEM_LATENCY reads can be outstanding when one returns.
  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    receiving |-> (issue_cnt_q > recv_cnt_q) &&
                  ((int'(issue_cnt_q) - int'(recv_cnt_q)) <= int'(MEM_LATENCY)));

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Sits between the I-cache/D-cache controller and the multi-cycle main memory.
- Arbitrates I-cache block misses, D-cache block misses and D-cache write-through stores onto the single memory port.
- Sequences 8-word block fills and streams the returned words, tagged with their address, back into the selected cache's data array.
- Asserts per-cache fill-done pulses that release the pipeline stall.

Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block (16-byte block).
- MEM_LATENCY, 4: cycles from a memory read issue to its mem_rvalid; the memory is pipelined.
- ADDR_W, 16: byte-address width.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- icache_miss  in  1  I-cache miss, level; held until icache_fill_done
- icache_miss_addr  in  ADDR_W  byte address of the missing fetch
- dcache_miss  in  1  D-cache miss, level; held until dcache_fill_done
- dcache_miss_addr  in  ADDR_W  byte address of the missing load/store
- dcache_wr_req  in  1  write-through store request, level; held until wr_ack
- dcache_wr_addr  in  ADDR_W  store byte address
- dcache_wr_data  in  16  store data
- wr_ack  out  1  one-cycle pulse; store accepted by memory
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read (valid when mem_en)
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  mem_rdata valid this cycle
- fill_we  out  1  write fill_data into the selected cache data array
- fill_sel  out  1  0 = I-cache, 1 = D-cache
- fill_addr  out  ADDR_W  byte address of the word being filled
- fill_data  out  16  word to write (mem_rdata passed through)
- fill_tag_we  out  1  write tag and valid bit for the block at fill_addr
- icache_fill_done  out  1  one-cycle pulse
- dcache_fill_done  out  1  one-cycle pulse
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WRITE, FILL. Counters: issue_cnt and recv_cnt, each 0..WORDS_PER_BLOCK.
- Reset: all outputs 0, state IDLE, counters 0.
- Reset mid-operation: abandons the fill or store. Any in-flight mem_rvalid is ignored afterwards, because mem_rvalid is ignored outside FILL.
- Requests are sampled only in IDLE. Priority: dcache_miss > dcache_wr_req > icache_miss.
  - A store that misses raises both dcache_miss and dcache_wr_req (write-allocate). The fill is served first, then the write.
- IDLE -> FILL:
  - Latch base = miss_addr with the low 4 bits cleared; latch fill_sel.
  - Clear both counters.
- FILL issue:
  - Each cycle while issue_cnt < 8: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; then issue_cnt++.
  - First issue occurs in the cycle after the request is sampled.
- FILL receive:
  - Each cycle with mem_rvalid: fill_we=1, fill_data=mem_rdata, fill_addr = base + 2*recv_cnt; then recv_cnt++.
  - Issue and receive overlap.
- FILL completion, on the 8th mem_rvalid:
  - fill_we, fill_tag_we and the selected *_fill_done all assert in the same cycle.
  - Next state is IDLE.
  - Request seen at cycle n gives done at cycle n+1+7+MEM_LATENCY (n+12 at defaults).
- WRITE:
  - Single cycle: mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data, wr_ack=1.
  - Next state is IDLE. A new request can be accepted one cycle later.
- Requester behaviour during FILL:
  - Requests dropping during FILL are ignored; the block still completes.
  - A waiting icache_miss is served after the current D operation.
- Address wrap: the block offset wraps within the block, so addresses never carry into the tag.
  - Example: base 0xFFF0 issues 0xFFF0..0xFFFE only.
- busy is combinational from state. The fill_* outputs are combinational from mem_rvalid and registers.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - The word index k starts at the missed word.
  - Issue and receive addresses are base + 2*((start+cnt) mod 8).
  - The same mod-8 ordering applies to fill_addr.
- Undefined: strictly ascending from word 0.
- Completion timing is identical with and without the macro.

Decomposition:
- Package cache_fill_pkg holds:
  - fill_state_e {IDLE, WRITE, FILL}
  - fill_src_e {SRC_ICACHE=0, SRC_DCACHE=1}
  - localparams BLOCK_OFFSET_W=4 and WORD_IDX_W=3
- No sub-module. Address generation is a single add/concatenate inside the block.

Test Plan:
- icache_miss, addr 0x0046: mem reads 0x0040..0x004E on 8 consecutive cycles; fill_sel=0; fill_we ×8 with matching fill_addr; fill_tag_we and icache_fill_done on the 8th word, exactly 12 cycles after the request.
- icache_miss and dcache_miss raised together: the D block fills first with dcache_fill_done, then the I fill starts the next cycle with icache_fill_done.
- Store miss (dcache_miss + dcache_wr_req, addr 0x1234, data 0xBEEF): fill of 0x1230..0x123E, then one write cycle with mem_wr=1, addr 0x1234, data 0xBEEF, wr_ack=1.
- rst asserted at the 3rd fill word: outputs 0 immediately; late mem_rvalid pulses produce no fill_we; a fresh miss then completes normally.
- Miss at 0xFFFA: addresses stay within 0xFFF0..0xFFFE.
  - With CRITICAL_WORD_FIRST_EN: order 0xFFFA, 0xFFFC, 0xFFFE, 0xFFF0, …
  - Without it: ascending from 0xFFF0.
